// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with freeze/flush handling and saturating
// stall, flush and bubble performance counters.
module id_exe_pipe_reg #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 clrCounters,
    input  logic [PC_WIDTH-1:0]  pcIn,
    input  logic [31:0]          valRnIn,
    input  logic [31:0]          valRmIn,
    input  logic [23:0]          signedImm24In,
    input  logic [11:0]          shiftOperandIn,
    input  logic [3:0]           exeCmdIn,
    input  logic [3:0]           destIn,
    input  logic [3:0]           src1In,
    input  logic [3:0]           src2In,
    input  logic                 immIn,
    input  logic                 wbEnIn,
    input  logic                 memReadIn,
    input  logic                 memWriteIn,
    input  logic                 bIn,
    input  logic                 sIn,
    input  logic [3:0]           statusIn,
    output logic [PC_WIDTH-1:0]  pcOut,
    output logic [31:0]          valRnOut,
    output logic [31:0]          valRmOut,
    output logic [23:0]          signedImm24Out,
    output logic [11:0]          shiftOperandOut,
    output logic [3:0]           exeCmdOut,
    output logic [3:0]           destOut,
    output logic [3:0]           src1Out,
    output logic [3:0]           src2Out,
    output logic                 immOut,
    output logic                 wbEnOut,
    output logic                 memReadOut,
    output logic                 memWriteOut,
    output logic                 bOut,
    output logic                 sOut,
    output logic [3:0]           statusOut,
    output logic                 validOut,
    output logic [CNT_WIDTH-1:0] stallCount,
    output logic [CNT_WIDTH-1:0] flushCount,
    output logic [CNT_WIDTH-1:0] bubbleCount
);

    logic [8:0] cv;
    logic       is_bubble;
    logic [2:0] inc;
    logic [CNT_WIDTH-1:0] cnt_reg [3];

    assign cv        = {exeCmdIn, memReadIn, memWriteIn, wbEnIn, bIn, sIn};
    assign is_bubble = (cv == 9'd0);

    // Increment qualifiers mirror the freeze > flush > load priority.
    assign inc[0] = freeze;
    assign inc[1] = !freeze && flush;
    assign inc[2] = !freeze && !flush && is_bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || (!freeze && flush)) begin
            pcOut           <= '0;
            valRnOut        <= '0;
            valRmOut        <= '0;
            signedImm24Out  <= '0;
            shiftOperandOut <= '0;
            exeCmdOut       <= '0;
            destOut         <= '0;
            src1Out         <= '0;
            src2Out         <= '0;
            immOut          <= 1'b0;
            wbEnOut         <= 1'b0;
            memReadOut      <= 1'b0;
            memWriteOut     <= 1'b0;
            bOut            <= 1'b0;
            sOut            <= 1'b0;
            statusOut       <= '0;
            validOut        <= 1'b0;
        end else if (!freeze) begin
            pcOut           <= pcIn;
            valRnOut        <= valRnIn;
            valRmOut        <= valRmIn;
            signedImm24Out  <= signedImm24In;
            shiftOperandOut <= shiftOperandIn;
            exeCmdOut       <= exeCmdIn;
            destOut         <= destIn;
            src1Out         <= src1In;
            src2Out         <= src2In;
            immOut          <= immIn;
            wbEnOut         <= wbEnIn;
            memReadOut      <= memReadIn;
            memWriteOut     <= memWriteIn;
            bOut            <= bIn;
            sOut            <= sIn;
            statusOut       <= statusIn;
            validOut        <= !is_bubble;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (clrCounters) begin
                    cnt_reg[gi] <= '0;
                end else if (inc[gi] && (cnt_reg[gi] != {CNT_WIDTH{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stallCount  = cnt_reg[0];
    assign flushCount  = cnt_reg[1];
    assign bubbleCount = cnt_reg[2];

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg, built with narrow counters so
// saturation is reachable quickly.
module tb_id_exe_pipe_reg;

    localparam int PW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst, freeze, flush, clrCounters;
    logic [PW-1:0] pcIn;
    logic [31:0] valRnIn, valRmIn;
    logic [23:0] signedImm24In;
    logic [11:0] shiftOperandIn;
    logic [3:0]  exeCmdIn, destIn, src1In, src2In, statusIn;
    logic immIn, wbEnIn, memReadIn, memWriteIn, bIn, sIn;

    logic [PW-1:0] pcOut;
    logic [31:0] valRnOut, valRmOut;
    logic [23:0] signedImm24Out;
    logic [11:0] shiftOperandOut;
    logic [3:0]  exeCmdOut, destOut, src1Out, src2Out, statusOut;
    logic immOut, wbEnOut, memReadOut, memWriteOut, bOut, sOut, validOut;
    logic [CW-1:0] stallCount, flushCount, bubbleCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_exe_pipe_reg #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .clrCounters(clrCounters),
        .pcIn(pcIn), .valRnIn(valRnIn), .valRmIn(valRmIn), .signedImm24In(signedImm24In),
        .shiftOperandIn(shiftOperandIn), .exeCmdIn(exeCmdIn), .destIn(destIn),
        .src1In(src1In), .src2In(src2In), .immIn(immIn), .wbEnIn(wbEnIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn), .bIn(bIn), .sIn(sIn),
        .statusIn(statusIn),
        .pcOut(pcOut), .valRnOut(valRnOut), .valRmOut(valRmOut),
        .signedImm24Out(signedImm24Out), .shiftOperandOut(shiftOperandOut),
        .exeCmdOut(exeCmdOut), .destOut(destOut), .src1Out(src1Out), .src2Out(src2Out),
        .immOut(immOut), .wbEnOut(wbEnOut), .memReadOut(memReadOut),
        .memWriteOut(memWriteOut), .bOut(bOut), .sOut(sOut), .statusOut(statusOut),
        .validOut(validOut), .stallCount(stallCount), .flushCount(flushCount),
        .bubbleCount(bubbleCount)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic clear_inputs();
        pcIn = '0; valRnIn = '0; valRmIn = '0; signedImm24In = '0; shiftOperandIn = '0;
        exeCmdIn = '0; destIn = '0; src1In = '0; src2In = '0; statusIn = '0;
        immIn = 0; wbEnIn = 0; memReadIn = 0; memWriteIn = 0; bIn = 0; sIn = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // T1: reset with nonzero inputs
        rst = 1; freeze = 0; flush = 0; clrCounters = 0;
        pcIn = 32'hdead; valRnIn = 32'h5; valRmIn = 32'h6; signedImm24In = 24'h7;
        shiftOperandIn = 12'h8; exeCmdIn = 4'h9; destIn = 4'h1; src1In = 4'h2; src2In = 4'h3;
        immIn = 1; wbEnIn = 1; memReadIn = 1; memWriteIn = 1; bIn = 1; sIn = 1; statusIn = 4'hf;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("t1_pc", pcOut, 0);
        check("t1_valrn", valRnOut, 0);
        check("t1_valid", validOut, 0);
        check("t1_stall", stallCount, 0);
        check("t1_flush", flushCount, 0);
        check("t1_bubble", bubbleCount, 0);

        // T2: single load
        clear_inputs();
        pcIn = 4; valRnIn = 32'h11; valRmIn = 32'h22; exeCmdIn = 4'b0010; wbEnIn = 1;
        destIn = 4'd3; statusIn = 4'b1010;
        step();
        check("t2_pc", pcOut, 4);
        check("t2_valrn", valRnOut, 32'h11);
        check("t2_valrm", valRmOut, 32'h22);
        check("t2_cmd", exeCmdOut, 4'b0010);
        check("t2_wben", wbEnOut, 1);
        check("t2_dest", destOut, 3);
        check("t2_status", statusOut, 4'b1010);
        check("t2_valid", validOut, 1);
        check("t2_bubble", bubbleCount, 0);

        // T3: freeze holds for 3 cycles
        freeze = 1; pcIn = 8; valRnIn = 32'h99;
        repeat (3) step();
        check("t3_pc_hold", pcOut, 4);
        check("t3_valrn_hold", valRnOut, 32'h11);
        check("t3_valid_hold", validOut, 1);
        check("t3_stall", stallCount, 3);
        freeze = 0;

        // T4: flush squashes, then freeze beats flush
        flush = 1;
        step();
        check("t4_pc", pcOut, 0);
        check("t4_cmd", exeCmdOut, 0);
        check("t4_wben", wbEnOut, 0);
        check("t4_valid", validOut, 0);
        check("t4_flush", flushCount, 1);
        flush = 0;
        step();
        check("t4_reload_pc", pcOut, 8);
        check("t4_reload_valid", validOut, 1);
        freeze = 1; flush = 1; pcIn = 16;
        step();
        check("t4_ff_pc", pcOut, 8);
        check("t4_ff_valid", validOut, 1);
        check("t4_ff_flush", flushCount, 1);
        check("t4_ff_stall", stallCount, 4);
        freeze = 0; flush = 0;

        // T5: bubbles, then clear during freeze
        clear_inputs();
        pcIn = 12; valRnIn = 32'h77; immIn = 1; statusIn = 4'h4;
        repeat (2) step();
        check("t5_valid", validOut, 0);
        check("t5_pc", pcOut, 12);
        check("t5_bubble", bubbleCount, 2);
        freeze = 1; clrCounters = 1; pcIn = 20;
        step();
        check("t5_clr_stall", stallCount, 0);
        check("t5_clr_flush", flushCount, 0);
        check("t5_clr_bubble", bubbleCount, 0);
        check("t5_clr_pc", pcOut, 12);
        clrCounters = 0;

        // T6: saturation and reset mid-freeze
        repeat (20) step();
        check("t6_stall_sat", stallCount, 15);
        check("t6_pc_hold", pcOut, 12);
        #2;
        rst = 1;
        #1;
        check("t6_rst_stall", stallCount, 0);
        check("t6_rst_pc", pcOut, 0);
        check("t6_rst_valrn", valRnOut, 0);
        check("t6_rst_imm", immOut, 0);
        rst = 0; freeze = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
